// File: rtl/vlsu_pkg.sv
// Shared constants and encodings for the vector load/store unit.
// Lane 0 of every 512-bit vector sits in the most significant word.
package vlsu_pkg;

    localparam int ADDR_W = 9;
    localparam int LANES  = 16;
    localparam int WORD_W = 32;
    localparam int VEC_W  = LANES * WORD_W;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_STORE = 2'b01,
        OP_COPY  = 2'b10,
        OP_RSVD  = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STORE,
        COPY_RD,
        COPY_WR,
        RESP
    } state_t;

endpackage

// File: rtl/vector_lsu.sv
// Sequences one 16-lane load, store or copy against the vector data memory
// and returns the resulting vector over a valid/ready response channel.
module vector_lsu #(
    parameter int ADDR_W = 9,
    parameter int LANES  = 16,
    parameter int WORD_W = 32,
    localparam int VEC_W = LANES * WORD_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [ADDR_W-1:0] req_addr2,
    input  logic [VEC_W-1:0]  req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [VEC_W-1:0]  rsp_rdata,
    output logic              rsp_err,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_address,
    output logic [VEC_W-1:0]  mem_write_data,
    input  logic [VEC_W-1:0]  mem_data_in
);

    import vlsu_pkg::*;

    state_t            state;
    logic [ADDR_W-1:0] dest_addr;
    logic [VEC_W-1:0]  data_buf;

    // Every output is registered and set on the edge that enters the state
    // it belongs to, so memory controls are stable for the whole cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            req_ready      <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_err        <= 1'b0;
            rsp_rdata      <= '0;
            mem_re         <= 1'b0;
            mem_we         <= 1'b0;
            mem_address    <= '0;
            mem_write_data <= '0;
            dest_addr      <= '0;
            data_buf       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        dest_addr <= req_addr2;
                        case (op_t'(req_op))
                            OP_LOAD: begin
                                mem_re      <= 1'b1;
                                mem_address <= req_addr;
                                state       <= LOAD;
                            end
                            OP_STORE: begin
                                mem_we         <= 1'b1;
                                mem_address    <= req_addr;
                                mem_write_data <= req_wdata;
                                data_buf       <= req_wdata;
                                state          <= STORE;
                            end
                            OP_COPY: begin
                                mem_re      <= 1'b1;
                                mem_address <= req_addr;
                                state       <= COPY_RD;
                            end
                            default: begin
                                data_buf  <= '0;
                                rsp_rdata <= '0;
                                rsp_err   <= 1'b1;
                                rsp_valid <= 1'b1;
                                state     <= RESP;
                            end
                        endcase
                    end
                end
                LOAD: begin
                    mem_re      <= 1'b0;
                    mem_address <= '0;
                    data_buf    <= mem_data_in;
                    rsp_rdata   <= mem_data_in;
                    rsp_valid   <= 1'b1;
                    state       <= RESP;
                end
                STORE, COPY_WR: begin
                    mem_we         <= 1'b0;
                    mem_address    <= '0;
                    mem_write_data <= '0;
                    rsp_rdata      <= data_buf;
                    rsp_valid      <= 1'b1;
                    state          <= RESP;
                end
                // The full source vector is captured before the write cycle,
                // which gives overlapping copies memmove behaviour.
                COPY_RD: begin
                    mem_re         <= 1'b0;
                    mem_we         <= 1'b1;
                    mem_address    <= dest_addr;
                    mem_write_data <= mem_data_in;
                    data_buf       <= mem_data_in;
                    state          <= COPY_WR;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= '0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/vector_lsu.md
# vector_lsu

Vector load/store unit placed directly upstream of the 512×32 vector data memory (`Dmem`). It accepts one 16-lane memory request at a time from the execute stage over a valid/ready handshake. It sequences the memory's `re`/`we`/`address`/`write_data` controls for load, store and memory-to-memory copy, then returns the 512-bit result over a valid/ready response channel.

## Interface
Parameters:
- `ADDR_W`, 9, word address width; matches the data memory depth of 512.
- `LANES`, 16, words per vector access.
- `WORD_W`, 32, bits per word. Vector width is `LANES*WORD_W`, which is 512.

Ports:
- `clock`  in  1  single clock; all state updates on posedge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit idle and able to accept.
- `req_op`  in  2  00 load, 01 store, 10 copy, 11 reserved.
- `req_addr`  in  9  load/store address; copy source.
- `req_addr2`  in  9  copy destination; ignored for the other ops.
- `req_wdata`  in  512  store data; lane 0 is in bits [511:480].
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_rdata`  out  512  load/copy data, or the store data echoed back.
- `rsp_err`  out  1  reserved op was issued.
- `mem_re`  out  1  drives memory `re`.
- `mem_we`  out  1  drives memory `we`.
- `mem_address`  out  9  drives memory `address`.
- `mem_write_data`  out  512  drives memory `write_data`.
- `mem_data_in`  in  512  memory `data_out`.

## Operation
- FSM states: IDLE, LOAD, STORE, COPY_RD, COPY_WR, RESP.
- `req_ready` = (state==IDLE). A request is accepted on the posedge where `req_valid && req_ready`. At acceptance, op, addresses and wdata are latched into internal registers.
- Transitions out of IDLE on acceptance:
  - op 00 → LOAD
  - op 01 → STORE
  - op 10 → COPY_RD
  - op 11 → RESP, with `rsp_err`=1 and `rsp_rdata`=0
- LOAD: `mem_re`=1, `mem_address`=addr. The unit captures `mem_data_in` into the data buffer at the end of the cycle, then goes to RESP.
- STORE: `mem_we`=1, `mem_address`=addr, `mem_write_data`=wdata for exactly one full cycle, so the memory's negedge write falls inside it. The data buffer is loaded with wdata. Next state is RESP.
- COPY_RD: same as LOAD, using the source address. Next state is COPY_WR.
- COPY_WR: `mem_we`=1, `mem_address`=addr2, `mem_write_data`=buffer. Next state is RESP.
- RESP: `rsp_valid`=1 and `rsp_rdata`=buffer, both held stable until `rsp_ready`. The posedge with `rsp_ready` returns the FSM to IDLE.
- `mem_re` and `mem_we` are never high together. Outside LOAD/STORE/COPY states both are 0, and `mem_address` and `mem_write_data` are 0.
- Addresses pass unmodified. Lane wrap-around (address+i mod 512) is performed by the memory, so address 505 touches words 505..511 and 0..8.
- Copy with overlapping source and destination has memmove semantics: the whole vector is read before any word is written.

## Timing
- Reset (`reset_n`=0, async): state=IDLE. The following outputs are 0: `req_ready` until release, `rsp_valid`, `rsp_err`, `rsp_rdata`, `mem_re`, `mem_we`, `mem_address`, `mem_write_data`. `req_ready`=1 from the first posedge after release.
- Reset asserted mid-operation abandons the operation immediately with no response. If it is asserted before the negedge of a STORE or COPY_WR cycle, no memory write occurs.
- Latency, counted from the acceptance posedge to the first posedge at which `rsp_valid` is sampled high:
  - load 2 cycles
  - store 2 cycles
  - copy 3 cycles
  - reserved op 1 cycle
- Throughput: one request in flight. The next request can be accepted on the posedge after the response handshake.
- Back-pressure: `rsp_ready` low holds RESP indefinitely, with all response outputs stable. `rsp_ready` high on the first RESP cycle gives a single-cycle response.

## Structure
- Package `vlsu_pkg`:
  - constants `ADDR_W`, `LANES`, `WORD_W`, `VEC_W`
  - op encoding `OP_LOAD`/`OP_STORE`/`OP_COPY`/`OP_RSVD`
  - FSM state encoding
- Single module `vector_lsu`, no sub-modules. The memory stays a separate instance wired by the parent.

## Test plan
- Store 0x00000000..0x0000000F (lane i = i) at address 32, then load 32 → `rsp_rdata` lanes 0..15 = 0..15, `rsp_err`=0, load latency 2.
- Store at 505, then load 0 → words 505..511 hold lanes 0..6; the load returns lanes 7..15 in lanes 0..8 (wrap-around).
- Fill 100..115 with 0xA0..0xAF, then copy 100→104 → words 104..119 = 0xA0..0xAF, `rsp_rdata` = the same vector, latency 3.
- Reserved op (11) → `rsp_valid` after 1 cycle, `rsp_err`=1, `rsp_rdata`=0, no `mem_re`/`mem_we` pulse.
- Hold `rsp_ready`=0 for 5 cycles after a load → `rsp_valid`/`rsp_rdata` stable and `req_ready`=0 throughout. Then raise `rsp_ready` → `req_ready`=1 on the next cycle.
- Assert `reset_n`=0 during the STORE cycle, before its negedge → memory contents at the target are unchanged, all outputs 0, and `req_ready`=1 one posedge after release.
